// File: rtl/eth_pkg.sv
// Shared constants, state type and helpers for the Ethernet receive framer
// and the CRC-32 byte engine.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
    localparam int          ETH_FCS_LEN     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } eth_rx_state_t;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] bitRev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 step: next register value after one byte,
// bits consumed LSB first. Shared with the transmit framer.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data_i[i]) ? ETH_CRC_POLY : 32'h0);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_rx_framer.sv
// Receive MAC framer: strips preamble/SFD and FCS, checks CRC-32, flags runt,
// oversize and PHY-error frames. Frame counters exist only with ETH_RX_STATS_EN.
module eth_rx_framer
    import eth_pkg::*;
#(
    parameter int MAX_LEN = 1514
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_d_i,
    input  logic        rx_dv_i,
    input  logic        rx_er_i,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_sof_o,
    output logic        m_eof_o,
    output logic        m_err_o,
    output logic [10:0] m_len_o
`ifdef ETH_RX_STATS_EN
    ,
    output logic [15:0] stat_good_o,
    output logic [15:0] stat_bad_o,
    output logic [15:0] stat_runt_o
`endif
);

    localparam int               CNT_W     = 12;
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(ETH_FCS_LEN + 1);
    localparam logic [CNT_W-1:0] OVR_IDX   = CNT_W'(MAX_LEN + ETH_FCS_LEN);
    localparam logic [10:0]      MAX_LEN_W = 11'(MAX_LEN);

    eth_rx_state_t    state_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic [4:0][7:0]  dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             sofPend_q;
    logic             crcOk;
    logic             frameBad;

    crc32_d8 u_crc (
        .crc_i (crc_q),
        .data_i(rx_d_i),
        .crc_o (crc_d)
    );

    // The residue constant is quoted MSB-first; our register shifts LSB-first.
    assign crcOk    = (bitRev32(crc_q) == ETH_CRC_RESIDUE);
    assign frameBad = ~crcOk | err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            crc_q     <= ETH_CRC_INIT;
            dly_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            sofPend_q <= 1'b0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eof_o   <= 1'b0;
            m_err_o   <= 1'b0;
            m_len_o   <= '0;
`ifdef ETH_RX_STATS_EN
            stat_good_o <= '0;
            stat_bad_o  <= '0;
            stat_runt_o <= '0;
`endif
        end else begin
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eof_o   <= 1'b0;
            m_err_o   <= 1'b0;
            m_len_o   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_dv_i) state_q <= ST_PREAMBLE;
                end
                ST_PREAMBLE: begin
                    if (!rx_dv_i) begin
                        state_q <= ST_IDLE;
                    end else if (rx_er_i) begin
                        state_q <= ST_DROP;
                    end else if (rx_d_i == ETH_SFD) begin
                        state_q   <= ST_DATA;
                        crc_q     <= ETH_CRC_INIT;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        sofPend_q <= 1'b1;
                    end else if (rx_d_i != ETH_PREAMBLE) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    // Five bytes held back so the FCS never reaches the output.
                    if (rx_dv_i) begin
                        crc_q <= crc_d;
                        dly_q <= {dly_q[3:0], rx_d_i};
                        err_q <= err_q | rx_er_i;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q >= MIN_CNT) begin
                            m_valid_o <= 1'b1;
                            m_data_o  <= dly_q[4];
                            m_sof_o   <= sofPend_q;
                            sofPend_q <= 1'b0;
                        end
                        if (cnt_q == OVR_IDX) begin
                            m_eof_o <= 1'b1;
                            m_err_o <= 1'b1;
                            m_len_o <= MAX_LEN_W;
                            state_q <= ST_DROP;
`ifdef ETH_RX_STATS_EN
                            stat_bad_o <= satInc(stat_bad_o);
`endif
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        if (cnt_q >= MIN_CNT) begin
                            m_valid_o <= 1'b1;
                            m_data_o  <= dly_q[4];
                            m_sof_o   <= sofPend_q;
                            sofPend_q <= 1'b0;
                            m_eof_o   <= 1'b1;
                            m_err_o   <= frameBad;
                            m_len_o   <= 11'(cnt_q - CNT_W'(ETH_FCS_LEN));
`ifdef ETH_RX_STATS_EN
                            if (frameBad) stat_bad_o  <= satInc(stat_bad_o);
                            else          stat_good_o <= satInc(stat_good_o);
`endif
                        end else begin
`ifdef ETH_RX_STATS_EN
                            stat_runt_o <= satInc(stat_runt_o);
`endif
                        end
                    end
                end
                ST_DROP: begin
                    if (!rx_dv_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Randomised bench for eth_rx_framer: frames are modelled as byte lists and
// expected payload bytes (with arrival cycle) are derived from framing rules.
module tb_eth_rx_framer;

    localparam int MAX_LEN = 16;

    typedef struct {
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] len;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  rxD;
    logic        rxDv;
    logic        rxEr;
    logic [7:0]  mData;
    logic        mValid;
    logic        mSof;
    logic        mEof;
    logic        mErr;
    logic [10:0] mLen;
`ifdef ETH_RX_STATS_EN
    logic [15:0] statGood;
    logic [15:0] statBad;
    logic [15:0] statRunt;
`endif

    longint     cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         mGood = 0;
    int         mBad = 0;
    int         mRunt = 0;
    exp_t       expQ[$];
    exp_t       monE;
    logic [7:0] frameQ[$];
    longint     tBase;
    int         kind;
    int         nBytes;
    int         erAt;
    bit         pBreak;
    bit         pErr;

    eth_rx_framer #(.MAX_LEN(MAX_LEN)) dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .rx_d_i   (rxD),
        .rx_dv_i  (rxDv),
        .rx_er_i  (rxEr),
        .m_data_o (mData),
        .m_valid_o(mValid),
        .m_sof_o  (mSof),
        .m_eof_o  (mEof),
        .m_err_o  (mErr),
        .m_len_o  (mLen)
`ifdef ETH_RX_STATS_EN
        ,
        .stat_good_o(statGood),
        .stat_bad_o (statBad),
        .stat_runt_o(statRunt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] refCrc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frameQ[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic buildFrame(input int p);
        logic [31:0] fcs;
        frameQ.delete();
        for (int i = 0; i < p; i++) frameQ.push_back(8'($urandom));
        fcs = refCrc(p);
        for (int b = 0; b < 4; b++) frameQ.push_back(fcs[8*b +: 8]);
    endtask

    task automatic checkStats();
`ifdef ETH_RX_STATS_EN
        checkOutput("stat_good", 64'(statGood), 64'(mGood));
        checkOutput("stat_bad", 64'(statBad), 64'(mBad));
        checkOutput("stat_runt", 64'(statRunt), 64'(mRunt));
`endif
    endtask

    // Each post-SFD byte j is driven at cycle t0+j; a byte that releases payload
    // k (either byte k+5 or the closing rx_dv=0) puts it on the output one cycle later.
    task automatic applyStimulus(input bit preBreak, input bit preEr, input int erIdx, input int ifg);
        longint      t0;
        int          total;
        int          p;
        bit          bad;
        exp_t        e;
        logic [31:0] fcs;
        total = frameQ.size();
        t0 = cyc + 8;
        if (!preBreak && !preEr) begin
            if (total >= MAX_LEN + 5) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    e.data = frameQ[k];
                    e.sof  = (k == 0);
                    e.eof  = (k == MAX_LEN - 1);
                    e.err  = 1'b1;
                    e.len  = 11'(MAX_LEN);
                    e.cyc  = t0 + k + 6;
                    expQ.push_back(e);
                end
                mBad++;
            end else if (total < 5) begin
                mRunt++;
            end else begin
                p   = total - 4;
                fcs = {frameQ[p+3], frameQ[p+2], frameQ[p+1], frameQ[p]};
                bad = (refCrc(p) != fcs) || (erIdx >= 0 && erIdx < total);
                for (int k = 0; k < p; k++) begin
                    e.data = frameQ[k];
                    e.sof  = (k == 0);
                    e.eof  = (k == p - 1);
                    e.err  = bad;
                    e.len  = 11'(p);
                    e.cyc  = t0 + k + 6;
                    expQ.push_back(e);
                end
                if (bad) mBad++;
                else     mGood++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            rxDv = 1'b1;
            rxD  = (preBreak && i == 3) ? 8'h00 : 8'h55;
            rxEr = preEr && (i == 2);
            @(negedge clk);
        end
        rxD  = 8'hD5;
        rxEr = 1'b0;
        @(negedge clk);
        for (int j = 0; j < total; j++) begin
            rxD  = frameQ[j];
            rxEr = (j == erIdx);
            @(negedge clk);
        end
        rxDv = 1'b0;
        rxD  = 8'h00;
        rxEr = 1'b0;
        repeat (1 + ifg) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rstN === 1'b1 && mValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_valid", 64'(mValid), 64'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("m_data", 64'(mData), 64'(monE.data));
                checkOutput("m_sof", 64'(mSof), 64'(monE.sof));
                checkOutput("m_eof", 64'(mEof), 64'(monE.eof));
                checkOutput("arrival_cycle", 64'(cyc), 64'(monE.cyc));
                if (monE.eof) begin
                    checkOutput("m_err", 64'(mErr), 64'(monE.err));
                    checkOutput("m_len", 64'(mLen), 64'(monE.len));
                end
            end
        end
    end

    initial begin
        rstN = 1'b0;
        rxD  = 8'h00;
        rxDv = 1'b0;
        rxEr = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", 64'(mValid), 64'd0);
        checkOutput("reset_len", 64'(mLen), 64'd0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_valid", 64'(mValid), 64'd0);
        checkOutput("idle_eof", 64'(mEof), 64'd0);
        checkStats();

        $display("[TB] good frame 123456789");
        frameQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        applyStimulus(1'b0, 1'b0, -1, 2);
        frameQ[12] = 8'hCA;
        applyStimulus(1'b0, 1'b0, -1, 2);

        $display("[TB] runts and single-byte payload");
        frameQ = '{8'h81, 8'h5A, 8'hA5, 8'h81};
        applyStimulus(1'b0, 1'b0, -1, 2);
        buildFrame(1);
        applyStimulus(1'b0, 1'b0, -1, 2);

        $display("[TB] preamble faults and rx_er");
        buildFrame(9);
        applyStimulus(1'b1, 1'b0, -1, 0);
        buildFrame(9);
        applyStimulus(1'b0, 1'b0, -1, 2);
        buildFrame(9);
        applyStimulus(1'b0, 1'b0, 4, 2);

        $display("[TB] oversize and back-to-back");
        buildFrame(30);
        applyStimulus(1'b0, 1'b0, -1, 0);
        buildFrame(MAX_LEN);
        applyStimulus(1'b0, 1'b0, -1, 0);
        buildFrame(7);
        applyStimulus(1'b0, 1'b0, -1, 0);
        repeat (4) @(negedge clk);
        checkStats();

        $display("[TB] reset mid-payload");
        frameQ.delete();
        for (int i = 0; i < 8; i++) frameQ.push_back(8'($urandom));
        tBase = cyc + 8;
        for (int k = 0; k < 2; k++) begin
            monE.data = frameQ[k];
            monE.sof  = (k == 0);
            monE.eof  = 1'b0;
            monE.err  = 1'b0;
            monE.len  = 11'd0;
            monE.cyc  = tBase + k + 6;
            expQ.push_back(monE);
        end
        rxDv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rxD = (i == 7) ? 8'hD5 : 8'h55;
            @(negedge clk);
        end
        for (int j = 0; j < 7; j++) begin
            rxD = frameQ[j];
            @(negedge clk);
        end
        rxD = frameQ[7];
        @(posedge clk);
        #2;
        checkOutput("prereset_valid", 64'(mValid), 64'd1);
        checkOutput("prereset_data", 64'(mData), 64'(frameQ[2]));
        rstN = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(mValid), 64'd0);
        checkOutput("midreset_data", 64'(mData), 64'd0);
        checkOutput("midreset_sof", 64'(mSof), 64'd0);
        mGood = 0;
        mBad  = 0;
        mRunt = 0;
        checkStats();
        rxDv = 1'b0;
        rxD  = 8'h00;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        checkOutput("reset_flush", 64'(expQ.size()), 64'd0);
        buildFrame(12);
        applyStimulus(1'b0, 1'b0, -1, 2);

        $display("[TB] random frames");
        for (int f = 0; f < 60; f++) begin
            kind   = $urandom_range(0, 9);
            erAt   = -1;
            pBreak = 1'b0;
            pErr   = 1'b0;
            if (kind == 0) begin
                nBytes = $urandom_range(0, 3);
                frameQ.delete();
                for (int i = 0; i < nBytes; i++) frameQ.push_back(8'($urandom));
            end else begin
                buildFrame($urandom_range(0, MAX_LEN + 6));
                if (kind == 1) frameQ[frameQ.size() - 1 - $urandom_range(0, 3)] ^= 8'($urandom_range(1, 255));
                if (kind == 2) erAt = $urandom_range(0, frameQ.size() - 1);
                if (kind == 3) pBreak = 1'b1;
                if (kind == 4) pErr = 1'b1;
            end
            applyStimulus(pBreak, pErr, erAt, $urandom_range(0, 3));
        end

        repeat (8) @(negedge clk);
        checkOutput("pending_expected", 64'(expQ.size()), 64'd0);
        checkStats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_rx_framer.md
# eth_rx_framer

Receive-side MAC framer that consumes the byte stream produced by `phy_100Mb` (`rx_d`/`rx_dv`/`rx_er`) and turns it into a payload byte stream. It strips preamble and SFD, removes the 4-byte FCS, checks CRC-32, and flags runt, oversize and PHY-error frames. It is clocked by the PHY byte clock `rx_clk` and feeds the SR2CB ring receive logic, which has no back-pressure.

## Interface
- `MAX_LEN`, 1514: maximum payload bytes per frame, excluding FCS; legal range 16..2043.
- `clk`  in  1  byte clock, driven by `phy_100Mb.rx_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_d`  in  8  received byte.
- `rx_dv`  in  1  byte valid; high for the whole frame including preamble.
- `rx_er`  in  1  PHY receive error; sampled only while `rx_dv` is high.
- `m_data`  out  8  payload byte.
- `m_valid`  out  1  `m_data` is valid this cycle.
- `m_sof`  out  1  first payload byte of the frame; qualified by `m_valid`.
- `m_eof`  out  1  last payload byte of the frame; qualified by `m_valid`.
- `m_err`  out  1  frame bad (CRC error, `rx_er` seen, or oversize); valid only with `m_eof`.
- `m_len`  out  11  payload byte count; valid only with `m_eof`.
- `stat_good`, `stat_bad`, `stat_runt`  out  16 each  frame counters; present only with `ETH_RX_STATS_EN`.

## Operation
- **States:**
  - IDLE: wait for `rx_dv`=1.
  - PREAMBLE: 0x55 stays here; 0xD5 goes to DATA; any other byte goes to DROP; `rx_dv`=0 returns to IDLE with no output.
  - DATA: shift bytes in; the first `rx_dv`=0 sample ends the frame and returns to IDLE.
  - DROP: wait for `rx_dv`=0, then go to IDLE.
- **CRC-32:** reflected form, polynomial 0xEDB88320. The register is set to 0xFFFFFFFF on SFD detection and updated with every DATA byte, FCS included. A frame is good when the register equals the residue 0xC704DD7B at frame end.
- **Delay line:** 5-byte shift register. When a byte arrives and 5 are already held, the oldest is emitted. This keeps the 4 FCS bytes held back at frame end.
- **End of frame** (`rx_dv` falls in DATA):
  - 5 or more post-SFD bytes received: emit the oldest held byte with `m_eof`=1.
    - `m_err` = CRC mismatch OR `rx_er` latched during the frame.
    - `m_len` = post-SFD bytes − 4.
  - Fewer than 5 post-SFD bytes: runt. Nothing is emitted and `stat_runt` increments.
- **Oversize:** when post-SFD byte index MAX_LEN+4 (0-based) is sampled, emit payload byte MAX_LEN−1 with `m_eof`=1, `m_err`=1, `m_len`=MAX_LEN, then go to DROP.
- **`rx_er`:**
  - During DATA: latched into the error flag; the frame continues.
  - During PREAMBLE: go to DROP.
- **`m_sof`:** asserted on the first emitted byte of a frame.
- **Single-byte payload:** `m_sof` and `m_eof` are asserted together on that byte.

## Timing
- **Reset:** all outputs are 0, `m_len`=0, counters are 0, state is IDLE. Reset asserted mid-frame aborts with no `m_eof`; the consumer shares `rst_n`.
- **Registered outputs:** all outputs are registered. `m_valid` is a one-cycle strobe per byte, with no handshake and no stall.
- **Payload latency:** payload byte D[k] appears one cycle after D[k+5] is sampled.
- **EOF latency:** the `m_eof` byte appears one cycle after the first `rx_dv`=0 sample.
- **Back-to-back frames:** a new preamble may start on the cycle after `rx_dv`=0 (IFG 0); the end-of-frame emission and the new preamble detection overlap without loss.
- **CRC datapath:** one byte per clock; the combinational next-state is computed in a single cycle.
- **Counters:** 16-bit, saturating at 0xFFFF. They update in the same cycle as the corresponding `m_eof` or runt detection.

## Configuration
- `ETH_RX_STATS_EN` defined:
  - `stat_good` counts frames ending with `m_err`=0.
  - `stat_bad` counts frames ending with `m_err`=1.
  - `stat_runt` counts runts.
- `ETH_RX_STATS_EN` undefined: the three ports and their counters are absent; all other behaviour is identical.

## Structure
- Package `eth_pkg` holds:
  - `ETH_PREAMBLE` (0x55), `ETH_SFD` (0xD5), `ETH_CRC_POLY`, `ETH_CRC_INIT`, `ETH_CRC_RESIDUE`, `ETH_FCS_LEN` (4);
  - the state enum `eth_rx_state_t`.
- Sub-module `crc32_d8`: purely combinational, next CRC from the current CRC and one data byte. The `phy_100Mb` transmit framer reuses it.

## Test plan
- **Good frame:** 7×0x55, 0xD5, ASCII "123456789", FCS 0x26 0x39 0xF4 0xCB, then `rx_dv`=0 → 9 bytes out, `m_sof` on 0x31, `m_eof` on 0x39, `m_err`=0, `m_len`=9, `stat_good`=1.
- **Corrupted FCS:** same frame with the last FCS byte changed to 0xCA → 9 bytes out, `m_eof` with `m_err`=1, `stat_bad`=1.
- **Runt:** preamble, SFD, then 0x81 0x5A 0xA5 0x81 and `rx_dv` low → no `m_valid`, `stat_runt`=1. With 1 payload byte + 4 FCS → `m_sof`=`m_eof`=1 on that byte.
- **Preamble faults:** preamble broken by 0x00 before SFD → no output; the following clean frame is received normally. `rx_er` pulsed mid-payload → `m_err`=1 and length unchanged.
- **Oversize:** `MAX_LEN`=16 with 30 payload bytes → 16 bytes out, `m_eof`+`m_err` on byte 16, `m_len`=16, nothing more until the next frame.
- **Back-to-back and reset:** two good frames with IFG 0 → both complete correctly. `rst_n` asserted mid-payload → outputs 0 immediately, and the next frame is received correctly.
